// File: rtl/up_down_counter_4bit_pkg.sv
// Shared width and mode definitions for the 4-bit synchronous up/down counter.
package up_down_counter_4bit_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } mode_e;

endpackage

// File: rtl/up_down_counter_4bit_t_flip_flop.sv
// Single T flip-flop stage: toggles on the rising clock edge when T is high.
// It is cleared asynchronously to 0 by rst.
module t_flip_flop
    import up_down_counter_4bit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic Q
);

    logic q_q;
    logic q_d;

    assign q_d = q_q ^ T;

    // NOTE: Flop state uses non-blocking assignment so that every stage samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/up_down_counter_4bit.sv
// 4-bit up/down counter built from four T flip-flops on one shared clock.
// A mode-steered carry/borrow chain selects which stages toggle.
module up_down_counter_4bit
    import up_down_counter_4bit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               M,
    output logic [COUNT_W-1:0] Q
);

    logic [COUNT_W-1:0] count_w;
    logic [COUNT_W-1:0] toggle_w;
    logic [COUNT_W-2:0] match_w;
    mode_e              mode_w;

    assign mode_w = mode_e'(M);

    // In up mode a stage carries when all lower bits are 1.
    // In down mode it borrows when all lower bits are 0.
    assign match_w = (mode_w == MODE_UP) ? count_w[COUNT_W-2:0] : ~count_w[COUNT_W-2:0];

    for (genvar i = 0; i < COUNT_W; i++) begin : g_stage
        if (i == 0) begin : g_lsb
            assign toggle_w[i] = 1'b1;
        end else begin : g_upper
            assign toggle_w[i] = &match_w[i-1:0];
        end

        t_flip_flop u_tff (
            .clk (clk),
            .rst (rst),
            .T   (toggle_w[i]),
            .Q   (count_w[i])
        );
    end

    assign Q = count_w;

endmodule

// File: tb/tb_up_down_counter_4bit.sv
// Directed bench for up_down_counter_4bit.
// A modular-arithmetic reference model is compared against Q on every falling clock edge.
module tb_up_down_counter_4bit;

    logic       clk;
    logic       rst;
    logic       M;
    logic [3:0] Q;

    int n_checks = 0;
    int n_pass   = 0;
    int model_q  = 0;

    up_down_counter_4bit dut (
        .clk (clk),
        .rst (rst),
        .M   (M),
        .Q   (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Reference model: cleared at once by reset, otherwise (Q +/- 1) mod 16 on each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q = 0;
        end else begin
            model_q = (model_q + (M ? 1 : 15)) % 16;
        end
    end

    always @(negedge clk) begin
        check("scoreboard", Q, 4'(model_q));
    end

    // Advance to just after the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        M   = 1'b1;
        #1 rst = 1'b1;
        #1 check("reset_async", Q, 4'd0);

        // Scenario 1: reset held across one edge, then count up.
        tick();
        check("reset_hold", Q, 4'd0);
        rst = 1'b0;
        tick(); check("s1_q1", Q, 4'd1);
        tick(); check("s1_q2", Q, 4'd2);
        tick(); check("s1_q3", Q, 4'd3);
        check("s1_model", 4'(model_q), 4'd3);

        // Scenario 2: 20 up-steps from reset, wrapping 15 -> 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        M   = 1'b1;
        ticks(15); check("s2_at15", Q, 4'd15);
        tick();    check("s2_wrap0", Q, 4'd0);
        ticks(4);  check("s2_end4", Q, 4'd4);

        // Scenario 3: 20 down-steps from 4 wrap 0 -> 15, and (4 - 20) mod 16 = 0.
        M = 1'b0;
        ticks(4);  check("s3_at0", Q, 4'd0);
        tick();    check("s3_wrap15", Q, 4'd15);
        ticks(15); check("s3_end", Q, 4'd0);
        check("s3_model", 4'(model_q), 4'd0);

        // Scenario 4: count down directly out of reset.
        rst = 1'b1;
        M   = 1'b0;
        tick();
        rst = 1'b0;
        tick(); check("s4_q15", Q, 4'd15);
        tick(); check("s4_q14", Q, 4'd14);
        tick(); check("s4_q13", Q, 4'd13);

        // Scenario 5: asynchronous reset between edges at Q = 9.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        M   = 1'b1;
        ticks(9);  check("s5_q9", Q, 4'd9);
        #1 rst = 1'b1;
        #1 check("s5_async_clear", Q, 4'd0);
        #2 rst = 1'b0;
        tick();    check("s5_resume1", Q, 4'd1);

        // Scenario 6: M glitches between edges, and only the value present at the edge counts.
        M = 1'b0;
        #1 check("s6_hold_a", Q, 4'd1);
        M = 1'b1;
        #1 check("s6_hold_b", Q, 4'd1);
        M = 1'b0;
        #2 check("s6_hold_c", Q, 4'd1);
        tick();    check("s6_step_down", Q, 4'd0);
        M = 1'b1;
        #1 M = 1'b0;
        #1 check("s6_hold_d", Q, 4'd0);
        M = 1'b1;
        #2 check("s6_hold_e", Q, 4'd0);
        tick();    check("s6_step_up", Q, 4'd1);

        // Mode reversal mid-count: from 4 counting up, M = 0 gives 3 on the next edge.
        ticks(3);  check("rev_q4", Q, 4'd4);
        M = 1'b0;
        tick();    check("rev_q3", Q, 4'd3);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
